// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues one instruction-memory request at a
// time, presents returned words to the fetch-to-decode register, holds a
// word while decode stalls, and handles redirects by flushing and dropping
// any response that belongs to the abandoned path.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_ack,
   input  logic        i_imem_rvalid,
   input  logic [31:0] i_imem_rdata,
   input  logic        i_stall,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   output logic        o_if_valid,
   output logic [31:0] o_if_pc,
   output logic [31:0] o_if_inst,
   output logic        o_flush
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;            // address of the next request
   logic [31:0] req_pc_q, req_pc_d;    // address of the outstanding request
   logic        drop_q, drop_d;        // outstanding response belongs to a dead path
   logic [31:0] hold_pc_q, hold_pc_d;  // one-entry hold buffer
   logic [31:0] hold_inst_q, hold_inst_d;

   logic [31:0] redirect_tgt;
   logic        unused_redirect_lsbs;

   // Redirect targets are forced onto a word boundary.
   assign redirect_tgt         = {i_redirect_pc[31:2], 2'b00};
   assign unused_redirect_lsbs = ^i_redirect_pc[1:0];

   // Next-state and output decode; reset forces outputs to their idle values.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      req_pc_d    = req_pc_q;
      drop_d      = drop_q;
      hold_pc_d   = hold_pc_q;
      hold_inst_d = hold_inst_q;
      o_imem_req  = 1'b0;
      o_imem_addr = pc_q;
      o_if_valid  = 1'b0;
      o_if_pc     = 32'h0;
      o_if_inst   = 32'h0;
      o_flush     = 1'b0;

      case (state_q)
         S_IDLE: begin
            state_d = S_REQ;
         end
         S_REQ: begin
            o_imem_req = 1'b1;
            if (i_redirect) begin
               o_flush     = 1'b1;
               pc_d        = redirect_tgt;
               hold_pc_d   = 32'h0;
               hold_inst_d = 32'h0;
               // A request accepted in the redirect cycle is for the old
               // path, so its response must be thrown away.
               if (i_imem_ack) begin
                  drop_d  = 1'b1;
                  state_d = S_WAIT;
               end
            end else if (i_imem_ack) begin
               req_pc_d = pc_q;
               state_d  = S_WAIT;
            end
         end
         S_WAIT: begin
            if (i_redirect) begin
               o_flush     = 1'b1;
               pc_d        = redirect_tgt;
               hold_pc_d   = 32'h0;
               hold_inst_d = 32'h0;
               if (i_imem_rvalid) begin
                  drop_d  = 1'b0;
                  state_d = S_REQ;
               end else begin
                  drop_d  = 1'b1;
               end
            end else if (i_imem_rvalid) begin
               if (drop_q) begin
                  drop_d  = 1'b0;
                  state_d = S_REQ;
               end else begin
                  o_if_valid = 1'b1;
                  o_if_pc    = req_pc_q;
                  o_if_inst  = i_imem_rdata;
                  if (i_stall) begin
                     hold_pc_d   = req_pc_q;
                     hold_inst_d = i_imem_rdata;
                     state_d     = S_HOLD;
                  end else begin
                     pc_d    = req_pc_q + 32'd4;
                     state_d = S_REQ;
                  end
               end
            end
         end
         S_HOLD: begin
            if (i_redirect) begin
               o_flush     = 1'b1;
               pc_d        = redirect_tgt;
               hold_pc_d   = 32'h0;
               hold_inst_d = 32'h0;
               state_d     = S_REQ;
            end else begin
               o_if_valid = 1'b1;
               o_if_pc    = hold_pc_q;
               o_if_inst  = hold_inst_q;
               if (!i_stall) begin
                  pc_d    = hold_pc_q + 32'd4;
                  state_d = S_REQ;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (rst) begin
         o_imem_req  = 1'b0;
         o_imem_addr = RESET_PC;
         o_if_valid  = 1'b0;
         o_if_pc     = 32'h0;
         o_if_inst   = 32'h0;
         o_flush     = 1'b0;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         pc_q        <= RESET_PC;
         req_pc_q    <= 32'h0;
         drop_q      <= 1'b0;
         hold_pc_q   <= 32'h0;
         hold_inst_q <= 32'h0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         req_pc_q    <= req_pc_d;
         drop_q      <= drop_d;
         hold_pc_q   <= hold_pc_d;
         hold_inst_q <= hold_inst_d;
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios followed by random traffic,
// every cycle checked against a transaction-level model of the fetch path.
module tb_fetch_ctrl;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_ack;
   logic        i_imem_rvalid;
   logic [31:0] i_imem_rdata;
   logic        i_stall;
   logic        i_redirect;
   logic [31:0] i_redirect_pc;
   logic        o_if_valid;
   logic [31:0] o_if_pc;
   logic [31:0] o_if_inst;
   logic        o_flush;

   int errors = 0;
   int checks = 0;

   // observed outputs of the most recent step
   logic        obs_req, obs_valid, obs_flush;
   logic [31:0] obs_addr, obs_pc, obs_inst;

   // model: architectural next-fetch pc plus memory-transaction bookkeeping
   logic [31:0] m_pc;
   logic        m_idle;       // first cycle after reset: nothing happens
   logic        m_out;        // a request has been accepted, no response yet
   logic [31:0] m_out_addr;
   logic        m_killed;     // outstanding response is from an abandoned path
   logic        m_held;       // an instruction is waiting for decode
   logic [31:0] m_held_pc, m_held_inst;

   fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
      .clk           (clk),
      .rst           (rst),
      .o_imem_req    (o_imem_req),
      .o_imem_addr   (o_imem_addr),
      .i_imem_ack    (i_imem_ack),
      .i_imem_rvalid (i_imem_rvalid),
      .i_imem_rdata  (i_imem_rdata),
      .i_stall       (i_stall),
      .i_redirect    (i_redirect),
      .i_redirect_pc (i_redirect_pc),
      .o_if_valid    (o_if_valid),
      .o_if_pc       (o_if_pc),
      .o_if_inst     (o_if_inst),
      .o_flush       (o_flush)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Compare this cycle's outputs with the model, then advance the model.
   task automatic model_cycle();
      logic        requesting, arrives, exp_valid;
      logic [31:0] exp_pc, exp_inst;
      if (rst) begin
         chk("rst_req",   {31'h0, obs_req},   32'h0);
         chk("rst_addr",  obs_addr,           RESET_PC);
         chk("rst_valid", {31'h0, obs_valid}, 32'h0);
         chk("rst_pc",    obs_pc,             32'h0);
         chk("rst_inst",  obs_inst,           32'h0);
         chk("rst_flush", {31'h0, obs_flush}, 32'h0);
         m_pc = RESET_PC; m_idle = 1'b1; m_out = 1'b0; m_killed = 1'b0; m_held = 1'b0;
         return;
      end
      requesting = !m_idle && !m_out && !m_held;
      arrives    = m_out && i_imem_rvalid;
      exp_valid  = 1'b0;
      exp_pc     = 32'h0;
      exp_inst   = 32'h0;
      if (m_held) begin
         exp_valid = 1'b1; exp_pc = m_held_pc; exp_inst = m_held_inst;
      end else if (arrives && !m_killed) begin
         exp_valid = 1'b1; exp_pc = m_out_addr; exp_inst = i_imem_rdata;
      end
      if (i_redirect && !m_idle) exp_valid = 1'b0;

      chk("imem_req", {31'h0, obs_req},   {31'h0, requesting});
      chk("flush",    {31'h0, obs_flush}, {31'h0, i_redirect && !m_idle});
      chk("if_valid", {31'h0, obs_valid}, {31'h0, exp_valid});
      if (requesting) chk("imem_addr", obs_addr, m_pc);
      if (exp_valid) begin
         chk("if_pc",   obs_pc,   exp_pc);
         chk("if_inst", obs_inst, exp_inst);
      end

      if (i_redirect && !m_idle) begin
         m_pc   = {i_redirect_pc[31:2], 2'b00};
         m_held = 1'b0;
         if (arrives) m_out = 1'b0;
         else if (m_out) m_killed = 1'b1;
         if (requesting && i_imem_ack) begin
            m_out = 1'b1; m_killed = 1'b1;
         end
      end else begin
         if (m_held && !i_stall) begin
            m_held = 1'b0;
            m_pc   = m_held_pc + 32'd4;
         end
         if (arrives) begin
            m_out = 1'b0;
            if (!m_killed) begin
               if (i_stall) begin
                  m_held = 1'b1; m_held_pc = m_out_addr; m_held_inst = i_imem_rdata;
               end else begin
                  m_pc = m_out_addr + 32'd4;
               end
            end
            m_killed = 1'b0;
         end
         if (requesting && i_imem_ack) begin
            m_out = 1'b1; m_out_addr = m_pc; m_killed = 1'b0;
         end
      end
      m_idle = 1'b0;
   endtask

   // One clock cycle: drive inputs, sample at the falling edge, check, advance.
   task automatic step(input logic r, input logic a, input logic v, input logic [31:0] d,
                       input logic s, input logic rd, input logic [31:0] rp);
      rst = r; i_imem_ack = a; i_imem_rvalid = v; i_imem_rdata = d;
      i_stall = s; i_redirect = rd; i_redirect_pc = rp;
      @(negedge clk);
      obs_req = o_imem_req; obs_addr = o_imem_addr; obs_valid = o_if_valid;
      obs_pc = o_if_pc; obs_inst = o_if_inst; obs_flush = o_flush;
      model_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      m_pc = RESET_PC; m_idle = 1'b1; m_out = 1'b0; m_out_addr = 32'h0; m_killed = 1'b0;
      m_held = 1'b0; m_held_pc = 32'h0; m_held_inst = 32'h0;
      rst = 1'b1; i_imem_ack = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = 32'h0;
      i_stall = 1'b0; i_redirect = 1'b0; i_redirect_pc = 32'h0;
      @(posedge clk); #1;

      // cold start
      step(1, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      chk("cold_idle_req", {31'h0, obs_req}, 32'h0);
      step(0, 1, 0, 0, 0, 0, 0);
      chk("cold_req", {31'h0, obs_req}, 32'h1);
      chk("cold_addr", obs_addr, 32'h0);
      step(0, 0, 1, 32'h0000_0013, 0, 0, 0);
      chk("cold_valid", {31'h0, obs_valid}, 32'h1);
      chk("cold_pc", obs_pc, 32'h0);
      chk("cold_inst", obs_inst, 32'h13);
      step(0, 1, 0, 0, 0, 0, 0);
      chk("cold_next_addr", obs_addr, 32'h4);
      step(0, 0, 1, 32'hA000_0004, 0, 0, 0);

      // stall hold at 0x8
      step(0, 1, 0, 0, 0, 0, 0);
      chk("stall_addr", obs_addr, 32'h8);
      step(0, 0, 1, 32'hA000_0008, 1, 0, 0);
      chk("stall_pc0", obs_pc, 32'h8);
      step(0, 0, 0, 0, 1, 0, 0);
      chk("stall_pc1", obs_pc, 32'h8);
      chk("stall_noreq", {31'h0, obs_req}, 32'h0);
      step(0, 0, 0, 0, 1, 0, 0);
      chk("stall_pc2", obs_pc, 32'h8);
      step(0, 0, 0, 0, 0, 0, 0);
      chk("stall_pc3", obs_pc, 32'h8);
      chk("stall_inst3", obs_inst, 32'hA000_0008);
      step(0, 1, 0, 0, 0, 0, 0);
      chk("stall_next_addr", obs_addr, 32'hC);
      step(0, 0, 1, 32'hA000_000C, 0, 0, 0);

      // redirect in WAIT
      step(0, 1, 0, 0, 0, 0, 0);
      chk("rw_addr", obs_addr, 32'h10);
      step(0, 0, 0, 0, 0, 1, 32'h0000_0103);
      chk("rw_flush", {31'h0, obs_flush}, 32'h1);
      step(0, 0, 1, 32'hDEAD_0010, 0, 0, 0);
      chk("rw_drop_valid", {31'h0, obs_valid}, 32'h0);
      chk("rw_flush_once", {31'h0, obs_flush}, 32'h0);
      step(0, 1, 0, 0, 0, 0, 0);
      chk("rw_next_addr", obs_addr, 32'h100);

      // redirect during stall in HOLD
      step(0, 0, 1, 32'hA000_0100, 1, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 1, 1, 32'h0000_0200);
      chk("rh_flush", {31'h0, obs_flush}, 32'h1);
      chk("rh_valid", {31'h0, obs_valid}, 32'h0);
      step(0, 1, 0, 0, 1, 0, 0);
      chk("rh_addr", obs_addr, 32'h200);
      step(0, 0, 1, 32'hA000_0200, 0, 0, 0);

      // wrap at the top of the address space
      step(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
      step(0, 1, 0, 0, 0, 0, 0);
      chk("wrap_addr", obs_addr, 32'hFFFF_FFFC);
      step(0, 0, 1, 32'hA000_FFFC, 0, 0, 0);
      chk("wrap_pc", obs_pc, 32'hFFFF_FFFC);
      step(0, 1, 0, 0, 0, 0, 0);
      chk("wrap_next_addr", obs_addr, 32'h0);

      // reset mid-WAIT with a stale response afterwards
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 1, 32'hBAD0_BAD0, 0, 0, 0);
      chk("stale_valid", {31'h0, obs_valid}, 32'h0);
      step(0, 1, 0, 0, 0, 0, 0);
      chk("post_rst_addr", obs_addr, RESET_PC);
      step(0, 0, 1, 32'h0000_0013, 0, 0, 0);
      chk("post_rst_pc", obs_pc, RESET_PC);

      // random traffic against the model
      for (int i = 0; i < 4000; i++) begin
         logic [31:0] tgt;
         tgt = $urandom();
         if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
         step(($urandom_range(0, 199) == 0),
              ($urandom_range(0, 1) == 0),
              ($urandom_range(0, 1) == 0),
              $urandom(),
              ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 15) == 0),
              tgt);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 o_imem_req  output  1  instruction memory request valid.
REQ-005 o_imem_addr  output  32  request address; word aligned.
REQ-006 i_imem_ack  input  1  memory accepts the request this cycle when o_imem_req=1.
REQ-007 i_imem_rvalid  input  1  read data valid for the single outstanding request.
REQ-008 i_imem_rdata  input  32  instruction word.
REQ-009 i_stall  input  1  decode cannot accept an instruction this cycle.
REQ-010 i_redirect  input  1  branch/jump redirect; one-cycle pulse.
REQ-011 i_redirect_pc  input  32  redirect target.
REQ-012 o_if_valid  output  1  o_if_pc/o_if_inst valid for the fetch-to-decode register.
REQ-013 o_if_pc  output  32  PC of the presented instruction.
REQ-014 o_if_inst  output  32  presented instruction word.
REQ-015 o_flush  output  1  clear the fetch-to-decode register this cycle.

Function
REQ-016 The block SHALL implement states IDLE, REQ, WAIT and HOLD, with at most one outstanding memory request.
REQ-017 IDLE: o_imem_req=0; next state REQ unconditionally.
REQ-018 REQ: o_imem_req=1 and o_imem_addr=pc; the request is held stable until i_imem_ack; on ack, latch req_pc=pc and go to WAIT.
REQ-019 WAIT: o_imem_req=0. On i_imem_rvalid with drop=0 and i_stall=0, present the instruction: o_if_valid=1, o_if_pc=req_pc, o_if_inst=i_imem_rdata. Set pc=req_pc+4 and go to REQ.
REQ-020 WAIT, i_imem_rvalid with drop=0 and i_stall=1: capture the data into a one-entry hold buffer and go to HOLD; o_if_valid=1 is still driven that cycle.
REQ-021 WAIT, i_imem_rvalid with drop=1: discard the data, clear drop, go to REQ with o_if_valid=0.
REQ-022 HOLD: o_if_valid=1 with the buffered pc and instruction. When i_stall=0, set pc=buffered pc+4 and go to REQ.
REQ-023 The instruction counts as consumed in the cycle where o_if_valid=1 and i_stall=0.
REQ-024 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC+4 = 32'h0000_0000).
REQ-025 Redirect has the highest priority and is valid in every state except IDLE:
- o_flush=1 and o_if_valid=0 in the same cycle.
- pc = {i_redirect_pc[31:2],2'b00}.
- The hold buffer is discarded.
REQ-026 Redirect in REQ without ack: go to REQ with the new pc next cycle.
REQ-027 Redirect in REQ with ack in the same cycle, or redirect in WAIT without rvalid: set drop=1 and go to WAIT.
REQ-028 Redirect in WAIT with rvalid in the same cycle: discard the data and go to REQ.
REQ-029 Redirect in HOLD: go to REQ.
REQ-030 Redirect with i_stall=1 SHALL still take effect.
REQ-031 i_imem_rvalid outside WAIT and i_imem_ack outside REQ SHALL be ignored.
REQ-032 The earliest response is rvalid one cycle after ack; rvalid in the same cycle as ack is ignored.
REQ-033 Fetch-to-present latency: one cycle after ack for zero-wait-state memory. Sustained throughput is one instruction per 2 cycles.

Reset
REQ-034 While rst=1, the block SHALL set state=IDLE, pc=RESET_PC, drop=0 and clear the hold buffer.
REQ-035 While rst=1, outputs SHALL be: o_imem_req=0, o_imem_addr=RESET_PC, o_if_valid=0, o_if_pc=0, o_if_inst=0, o_flush=0.
REQ-036 Reset asserted mid-operation SHALL abandon any outstanding request. Responses arriving after reset release are ignored until a new ack.

Verification
REQ-037 Cold start: release rst, ack immediately, rvalid next cycle with data 32'h0000_0013, i_stall=0.
- Expected: req at addr 0x0 in the cycle after IDLE.
- Then o_if_valid=1, pc 0x0, inst 0x13.
- Next request at 0x4.
REQ-038 Stall hold: rvalid with pc 0x8 while i_stall=1 for 3 cycles.
- Expected: o_if_valid=1 with pc 0x8 in all 4 cycles, no new request.
- After stall drops: request at 0xC.
REQ-039 Redirect in WAIT: ack at 0x10, then i_redirect with target 0x103 before rvalid.
- Expected: o_flush=1 for one cycle.
- The following rvalid is dropped with o_if_valid=0.
- Next request at 0x100.
REQ-040 Redirect during stall in HOLD to 0x200.
- Expected: flush, buffer discarded, next request at 0x200.
REQ-041 Wrap: redirect to 0xFFFF_FFFC, fetch it with i_stall=0.
- Expected: next request at 0x0000_0000.
REQ-042 Reset mid-WAIT: assert rst for 1 cycle after ack, then a stale rvalid arrives.
- Expected: all outputs at reset values, stale data ignored, request at RESET_PC.
